otter_io_hub: RTL and testbench



---
 rtl/otter_io_hub_pkg.sv | 33 +++
 rtl/otter_io_hub_if.sv | 14 +
 rtl/otter_io_hub_sync_edge.sv | 31 +++
 rtl/otter_io_hub.sv | 94 +++++++++
 tb/tb_otter_io_hub.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_io_hub_pkg.sv
// Shared types, default address map and decode helpers for the OTTER I/O hub.
// Build option IO_HUB_READBACK_EN, used in otter_io_hub.sv, changes nothing in this package.
package otter_io_pkg;

  typedef logic [31:0] word_t;

  localparam word_t OUT_BASE_DEFAULT = 32'h1100C000;
  localparam word_t IN_BASE_DEFAULT  = 32'h11008000;
  localparam word_t IRQ_BASE_DEFAULT = 32'h1100E000;

  localparam word_t IRQ_MASK_OFS = 32'h0;
  localparam word_t IRQ_PEND_OFS = 32'h4;

  typedef struct packed {
    logic       hit;
    logic [4:0] idx;
  } dec_t;

  // Word-aligned match inside [base, base + 4*n). Addresses below base wrap to a huge offset.
  function automatic dec_t addr_decode(word_t addr, word_t base, int unsigned n);
    dec_t  r;
    word_t ofs;
    ofs   = addr - base;
    r.hit = (addr[1:0] == 2'b00) && (ofs < 4 * n);
    r.idx = ofs[6:2];
    return r;
  endfunction

  function automatic logic windows_overlap(word_t a, int unsigned a_len, word_t b, int unsigned b_len);
    return (a < b + b_len) && (b < a + a_len);
  endfunction

endpackage

// File: rtl/otter_io_hub_if.sv
// MCU-side I/O bus of the OTTER hub.
// IOBUS_WR is the only qualifier: a one-cycle write strobe with no back-pressure; IOBUS_IN is a
// combinational read of IOBUS_ADDR and is always valid.
interface otter_io_hub_if;
  import otter_io_pkg::*;

  word_t IOBUS_ADDR;
  word_t IOBUS_OUT;
  logic  IOBUS_WR;
  word_t IOBUS_IN;

  modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
  modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/otter_io_hub_sync_edge.sv
// Multi-flop synchroniser with a history flop: q is the synchronised level, rise pulses one
// cycle when q goes 0->1.
module io_sync_edge #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [STAGES-1:0][W-1:0] chain;
  logic [W-1:0]             hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      hist  <= '0;
    end else begin
      chain[0] <= d;
      for (int s = 1; s < STAGES; s++) chain[s] <= chain[s-1];
      hist <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~hist;

endmodule

// File: rtl/otter_io_hub.sv
// Memory-mapped I/O hub: output registers, synchronised input ports and an interrupt aggregator.
// Define IO_HUB_READBACK_EN to make output registers readable at their write addresses.
module otter_io_hub
  import otter_io_pkg::*;
#(
  parameter int    N_OUT       = 4,
  parameter int    N_IN        = 4,
  parameter int    N_IRQ       = 4,
  parameter int    SYNC_STAGES = 2,
  parameter word_t BASE_OUT    = OUT_BASE_DEFAULT,
  parameter word_t BASE_IN     = IN_BASE_DEFAULT,
  parameter word_t BASE_IRQ    = IRQ_BASE_DEFAULT
) (
  input  logic                   CLK,
  input  logic                   RESET,
  otter_io_hub_if.slave          bus,
  input  logic [N_IN-1:0][31:0]  in_ports,
  output logic [N_OUT-1:0][31:0] out_ports,
  input  logic [N_IRQ-1:0]       irq_src,
  output logic                   INTR
);

  localparam int unsigned OUT_LEN   = 4 * N_OUT;
  localparam int unsigned IN_LEN    = 4 * N_IN;
  localparam word_t       MASK_ADDR = BASE_IRQ + IRQ_MASK_OFS;
  localparam word_t       PEND_ADDR = BASE_IRQ + IRQ_PEND_OFS;

  if (windows_overlap(BASE_OUT, OUT_LEN, BASE_IN, IN_LEN) ||
      windows_overlap(BASE_OUT, OUT_LEN, BASE_IRQ, 8) ||
      windows_overlap(BASE_IN, IN_LEN, BASE_IRQ, 8)) begin : g_bad_map
    $error("otter_io_hub: address windows overlap");
  end

  dec_t                  out_dec, in_dec;
  logic                  mask_sel, pend_sel;
  logic [N_IRQ-1:0]      irq_mask, irq_pend, irq_edge, irq_level_unused, pend_clr;
  logic [N_IN-1:0][31:0] in_sync, in_edge_unused;

  assign out_dec  = addr_decode(bus.IOBUS_ADDR, BASE_OUT, N_OUT);
  assign in_dec   = addr_decode(bus.IOBUS_ADDR, BASE_IN, N_IN);
  assign mask_sel = (bus.IOBUS_ADDR == MASK_ADDR);
  assign pend_sel = (bus.IOBUS_ADDR == PEND_ADDR);

  for (genvar g = 0; g < N_IN; g++) begin : g_in
    io_sync_edge #(.STAGES(SYNC_STAGES), .W(32)) u_sync (
      .clk (CLK), .rst (RESET), .d (in_ports[g]), .q (in_sync[g]), .rise (in_edge_unused[g])
    );
  end

  for (genvar g = 0; g < N_IRQ; g++) begin : g_irq
    io_sync_edge #(.STAGES(SYNC_STAGES), .W(1)) u_sync (
      .clk (CLK), .rst (RESET), .d (irq_src[g]), .q (irq_level_unused[g]), .rise (irq_edge[g])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_ports <= '0;
    end else begin
      for (int i = 0; i < N_OUT; i++)
        if (bus.IOBUS_WR && out_dec.hit && out_dec.idx == 5'(i)) out_ports[i] <= bus.IOBUS_OUT;
    end
  end

  assign pend_clr = (bus.IOBUS_WR && pend_sel) ? bus.IOBUS_OUT[N_IRQ-1:0] : '0;

  // A new edge ORed in after the clear, so set beats a same-cycle acknowledge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      irq_mask <= '0;
      irq_pend <= '0;
      INTR     <= 1'b0;
    end else begin
      if (bus.IOBUS_WR && mask_sel) irq_mask <= bus.IOBUS_OUT[N_IRQ-1:0];
      irq_pend <= (irq_pend & ~pend_clr) | irq_edge;
      INTR     <= |(irq_pend & irq_mask);
    end
  end

  always_comb begin
    bus.IOBUS_IN = '0;
    for (int i = 0; i < N_IN; i++)
      if (in_dec.hit && in_dec.idx == 5'(i)) bus.IOBUS_IN = in_sync[i];
`ifdef IO_HUB_READBACK_EN
    for (int i = 0; i < N_OUT; i++)
      if (out_dec.hit && out_dec.idx == 5'(i)) bus.IOBUS_IN = out_ports[i];
`else
    if (out_dec.hit) bus.IOBUS_IN = '0;
`endif
    if (mask_sel) bus.IOBUS_IN = word_t'(irq_mask);
    if (pend_sel) bus.IOBUS_IN = word_t'(irq_pend);
  end

endmodule

// File: tb/tb_otter_io_hub.sv
// Directed plus randomised bench for otter_io_hub against a sample-history reference model.
module tb_otter_io_hub;
  import otter_io_pkg::*;

  localparam int    N_OUT = 4;
  localparam int    N_IN  = 4;
  localparam int    N_IRQ = 4;
  localparam int    S     = 2;
  localparam word_t B_OUT = 32'h1100C000;
  localparam word_t B_IN  = 32'h11008000;
  localparam word_t A_MSK = 32'h1100E000;
  localparam word_t A_PND = 32'h1100E004;

  // clock / reset
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  otter_io_hub_if bus ();
  logic [N_IN-1:0][31:0]  in_ports;
  logic [N_OUT-1:0][31:0] out_ports;
  logic [N_IRQ-1:0]       irq_src;
  logic                   INTR;

  otter_io_hub #(.N_OUT(N_OUT), .N_IN(N_IN), .N_IRQ(N_IRQ), .SYNC_STAGES(S)) dut (
    .CLK (CLK), .RESET (RESET), .bus (bus), .in_ports (in_ports),
    .out_ports (out_ports), .irq_src (irq_src), .INTR (INTR)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: register contents plus the history of values sampled at each edge
  word_t            m_out [N_OUT];
  logic [N_IRQ-1:0] m_mask, m_pend;
  logic             m_intr;
  logic [N_IRQ-1:0] m_irq_h [S+1];
  word_t            m_in_h [N_IN][S];

  task automatic check(string tag, word_t obs, word_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < N_OUT; i++) m_out[i] = '0;
    for (int i = 0; i < N_IN; i++) for (int k = 0; k < S; k++) m_in_h[i][k] = '0;
    for (int k = 0; k <= S; k++) m_irq_h[k] = '0;
    m_mask = '0; m_pend = '0; m_intr = 1'b0;
  endtask

  function automatic word_t m_read(word_t a);
    if (a == A_MSK) return word_t'(m_mask);
    if (a == A_PND) return word_t'(m_pend);
    for (int i = 0; i < N_IN; i++) if (a == B_IN + 4 * i) return m_in_h[i][S-1];
`ifdef IO_HUB_READBACK_EN
    for (int i = 0; i < N_OUT; i++) if (a == B_OUT + 4 * i) return m_out[i];
`endif
    return '0;
  endfunction

  // One rising edge: the level sampled S-1 edges ago is the synchronised value; an edge is
  // that value being 1 where the one before was 0, and it lands in pending one edge later.
  task automatic m_step(logic wr, word_t a, word_t d, logic [N_IRQ-1:0] irq, logic [N_IN-1:0][31:0] inp);
    logic [N_IRQ-1:0] rise, clr;
    rise   = m_irq_h[S-1] & ~m_irq_h[S];
    clr    = (wr && a == A_PND) ? d[N_IRQ-1:0] : '0;
    m_intr = |(m_pend & m_mask);
    m_pend = (m_pend & ~clr) | rise;
    if (wr && a == A_MSK) m_mask = d[N_IRQ-1:0];
    for (int i = 0; i < N_OUT; i++) if (wr && a == B_OUT + 4 * i) m_out[i] = d;
    for (int k = S; k > 0; k--) m_irq_h[k] = m_irq_h[k-1];
    m_irq_h[0] = irq;
    for (int i = 0; i < N_IN; i++) begin
      for (int k = S - 1; k > 0; k--) m_in_h[i][k] = m_in_h[i][k-1];
      m_in_h[i][0] = inp[i];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N_OUT; i++) check($sformatf("out%0d", i), out_ports[i], m_out[i]);
    check("intr", word_t'(INTR), word_t'(m_intr));
    check("rdata", bus.IOBUS_IN, m_read(bus.IOBUS_ADDR));
  endtask

  // driver tasks
  task automatic tick();
    logic                  wr_c;
    word_t                 a_c, d_c;
    logic [N_IRQ-1:0]      irq_c;
    logic [N_IN-1:0][31:0] in_c;
    wr_c = bus.IOBUS_WR; a_c = bus.IOBUS_ADDR; d_c = bus.IOBUS_OUT;
    irq_c = irq_src; in_c = in_ports;
    @(posedge CLK);
    #1;
    if (RESET) m_reset();
    else m_step(wr_c, a_c, d_c, irq_c, in_c);
    check_all();
  endtask

  task automatic bus_write(word_t a, word_t d);
    bus.IOBUS_ADDR = a; bus.IOBUS_OUT = d; bus.IOBUS_WR = 1'b1;
    tick();
    bus.IOBUS_WR = 1'b0;
  endtask

  task automatic read_at(word_t a);
    bus.IOBUS_ADDR = a;
    #1;
  endtask

  initial begin
    word_t a;
    RESET = 1'b1;
    bus.IOBUS_ADDR = B_IN; bus.IOBUS_OUT = '0; bus.IOBUS_WR = 1'b0;
    in_ports = '0; irq_src = '0;
    m_reset();
    #2;
    check("reset_out", out_ports, '0);
    check("reset_intr", word_t'(INTR), 32'h0);
    tick(); tick();
    RESET = 1'b0;
    tick();

    // output register write, one-edge latency
    bus_write(B_OUT + 4, 32'h0000A5A5);
    check("out1_written", out_ports[1], 32'h0000A5A5);
    check("out0_untouched", out_ports[0], 32'h0);
    read_at(B_OUT + 4);
`ifdef IO_HUB_READBACK_EN
    check("readback_out1", bus.IOBUS_IN, 32'h0000A5A5);
`else
    check("readback_out1", bus.IOBUS_IN, 32'h0);
`endif

    // input synchroniser latency and decode edges
    in_ports[2] = 32'h0000BEEF;
    read_at(B_IN + 8);
    check("in2_before", bus.IOBUS_IN, 32'h0);
    for (int t = 1; t < S; t++) tick();
    check("in2_early", bus.IOBUS_IN, 32'h0);
    tick();
    check("in2_after", bus.IOBUS_IN, 32'h0000BEEF);
    read_at(32'h11008003);
    check("misaligned", bus.IOBUS_IN, 32'h0);
    read_at(B_IN + 4 * N_IN);
    check("past_in_window", bus.IOBUS_IN, 32'h0);

    // masked source: pulse, pending, INTR, acknowledge
    bus_write(A_MSK, 32'h1);
    read_at(A_PND);
    irq_src[0] = 1'b1;
    for (int t = 1; t <= S + 2; t++) begin
      tick();
      if (t == 3) irq_src[0] = 1'b0;
      if (t == S + 1) begin
        check("pend0_set", bus.IOBUS_IN, 32'h1);
        check("intr_not_yet", word_t'(INTR), 32'h0);
      end
    end
    check("intr_raised", word_t'(INTR), 32'h1);
    bus_write(A_PND, 32'h1);
    check("intr_w1c_edge", word_t'(INTR), 32'h1);
    tick();
    check("intr_w1c_drop", word_t'(INTR), 32'h0);

    // pending while masked, then unmask
    bus_write(A_MSK, 32'h0);
    irq_src[2] = 1'b1;
    for (int t = 0; t < S + 3; t++) tick();
    check("masked_intr", word_t'(INTR), 32'h0);
    read_at(A_PND);
    check("pend2_latched", bus.IOBUS_IN, 32'h4);
    bus_write(A_MSK, 32'h4);
    check("unmask_edge", word_t'(INTR), 32'h0);
    tick();
    check("unmask_intr", word_t'(INTR), 32'h1);
    irq_src[2] = 1'b0;
    bus_write(A_PND, 32'h4);

    // set beats clear on the same edge
    irq_src[0] = 1'b1;
    for (int t = 0; t <= S; t++) tick();
    irq_src[0] = 1'b0;
    for (int t = 0; t <= S + 1; t++) tick();
    irq_src[0] = 1'b1;
    for (int t = 0; t < S; t++) tick();
    bus_write(A_PND, 32'h1);
    read_at(A_PND);
    check("set_wins", bus.IOBUS_IN, 32'h1);
    irq_src[0] = 1'b0;

    // randomised traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0: a = B_OUT + 4 * $urandom_range(0, N_OUT - 1);
        1: a = B_IN + 4 * $urandom_range(0, N_IN - 1);
        2: a = A_MSK;
        3: a = A_PND;
        4: a = B_IN + 4 * $urandom_range(0, N_IN - 1) + $urandom_range(1, 3);
        default: a = B_OUT + 4 * N_OUT;
      endcase
      bus.IOBUS_ADDR = a;
      bus.IOBUS_OUT  = $urandom;
      bus.IOBUS_WR   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) irq_src = N_IRQ'($urandom);
      if ($urandom_range(0, 3) == 0) in_ports[$urandom_range(0, N_IN - 1)] = $urandom;
      tick();
    end
    bus.IOBUS_WR = 1'b0;

    // asynchronous reset with INTR high and out0 set
    irq_src = '0;
    for (int t = 0; t < S + 2; t++) tick();
    bus_write(A_PND, 32'hF);
    bus_write(B_OUT, 32'h0000FFFF);
    bus_write(A_MSK, 32'hF);
    irq_src[1] = 1'b1;
    for (int t = 0; t < S + 2; t++) tick();
    check("pre_reset_intr", word_t'(INTR), 32'h1);
    check("pre_reset_out0", out_ports[0], 32'h0000FFFF);
    #3;
    RESET = 1'b1;
    #1;
    m_reset();
    check("async_out", out_ports, '0);
    check("async_intr", word_t'(INTR), 32'h0);
    read_at(A_PND);
    check("async_pend", bus.IOBUS_IN, 32'h0);
    tick();
    RESET = 1'b0;
    for (int t = 0; t < S + 3; t++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
